// File: rtl/math_func_sched.sv
// math_func_sched: round-robin scheduler sharing one iterative math engine
// (sin/cos/Ln/exp) among NREQ requesters. Arbitrates, latches the winner's
// operand and function code, runs the engine start/Ready handshake, returns
// the result with a per-requester done pulse, and aborts hung transactions.
//
// Handshake semantics:
//   requester side: req[i] is a level request held until done[i]; the
//     operand and function slices are sampled only in the arbitration cycle.
//     done[i] is a one-cycle pulse; result is valid in that cycle and held
//     until the next done. err[i] accompanies done[i] when the engine timed
//     out, and result is then 0.
//   engine side: a start is issued only while eng_ready=1; eng_start is high
//     for exactly one cycle, after which the engine must drop eng_ready and
//     raise it again; eng_result is sampled in the cycle eng_ready returns.
module math_func_sched #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int TMO  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   func_in,
  input  logic [W*NREQ-1:0]   x_in,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic [NREQ-1:0]     err,
  output logic [W-1:0]        result,
  output logic                eng_start,
  output logic [1:0]          eng_func,
  output logic [W-1:0]        eng_x,
  input  logic                eng_ready,
  input  logic [W-1:0]        eng_result,
  output logic                busy,
  output logic [2:0]          state_dbg
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO) + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DELIVER   = 3'd4,
    S_ERR       = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic [CW-1:0]   cnt;
  logic            tmo_hit;

  logic [1:0]      func_a [NREQ];
  logic [W-1:0]    x_a    [NREQ];

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;

  // Unpack the flat per-requester buses into indexable arrays
  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign func_a[i] = func_in[2*i +: 2];
    assign x_a[i]    = x_in[W*i +: W];
  end

  assign tmo_hit   = (cnt == CW'(TMO - 1));
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Round-robin search: first requester above the pointer, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; Ready returning wins over a same-cycle timeout
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (win_found && eng_ready) begin
          state_nx = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_nx = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!eng_ready) begin
          state_nx = S_WAIT_DONE;
        end else if (tmo_hit) begin
          state_nx = S_ERR;
        end
      end
      S_WAIT_DONE: begin
        if (eng_ready) begin
          state_nx = S_DELIVER;
        end else if (tmo_hit) begin
          state_nx = S_ERR;
        end
      end
      S_DELIVER: begin
        state_nx = S_IDLE;
      end
      S_ERR: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Registered grant, engine operands, timeout counter, result and pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      result    <= '0;
      eng_start <= 1'b0;
      eng_func  <= '0;
      eng_x     <= '0;
      ptr       <= IW'(NREQ - 1);
      gidx      <= '0;
      cnt       <= '0;
    end else begin
      eng_start <= (state_nx == S_LAUNCH);
      done      <= '0;
      err       <= '0;
      case (state)
        S_IDLE: begin
          if (state_nx == S_LAUNCH) begin
            gnt      <= NREQ'(1) << win_idx;
            gidx     <= win_idx;
            eng_func <= func_a[win_idx];
            eng_x    <= x_a[win_idx];
          end
        end
        S_LAUNCH: begin
          cnt <= '0;
        end
        S_WAIT_BUSY, S_WAIT_DONE: begin
          cnt <= cnt + 1'b1;
          if (state_nx == S_DELIVER) begin
            result <= eng_result;
            done   <= gnt;
          end else if (state_nx == S_ERR) begin
            result <= '0;
            done   <= gnt;
            err    <= gnt;
          end
        end
        S_DELIVER, S_ERR: begin
          gnt <= '0;
          ptr <= gidx;
        end
        default: begin
          gnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_math_func_sched.sv
// tb_math_func_sched: directed bench for math_func_sched. Stimulus pushes the
// expected done/err/result triple into exp_q; a negedge monitor pops and
// compares on every done pulse. A second instance with TMO=16 and a hung
// engine covers the watchdog path.
module tb_math_func_sched;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int EW   = 2*NREQ + W;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] func_in;
  logic [W*NREQ-1:0] x_in;
  logic [NREQ-1:0]   gnt, done, err;
  logic [W-1:0]      result;
  logic              eng_start;
  logic [1:0]        eng_func;
  logic [W-1:0]      eng_x;
  logic              eng_ready;
  logic [W-1:0]      eng_result;
  logic              busy;
  logic [2:0]        state_dbg;

  // Watchdog instance
  logic [NREQ-1:0]   t_req;
  logic [2*NREQ-1:0] t_func_in;
  logic [W*NREQ-1:0] t_x_in;
  logic [NREQ-1:0]   t_gnt, t_done, t_err;
  logic [W-1:0]      t_result;
  logic              t_eng_start;
  logic [1:0]        t_eng_func;
  logic [W-1:0]      t_eng_x;
  logic              t_eng_ready;
  logic [W-1:0]      t_eng_result;
  logic              t_busy;
  logic [2:0]        t_state_dbg;

  math_func_sched #(.NREQ(NREQ), .W(W), .TMO(64)) dut (
    .clk(clk), .rst(rst), .req(req), .func_in(func_in), .x_in(x_in),
    .gnt(gnt), .done(done), .err(err), .result(result),
    .eng_start(eng_start), .eng_func(eng_func), .eng_x(eng_x),
    .eng_ready(eng_ready), .eng_result(eng_result),
    .busy(busy), .state_dbg(state_dbg)
  );

  math_func_sched #(.NREQ(NREQ), .W(W), .TMO(16)) dut_t (
    .clk(clk), .rst(rst), .req(t_req), .func_in(t_func_in), .x_in(t_x_in),
    .gnt(t_gnt), .done(t_done), .err(t_err), .result(t_result),
    .eng_start(t_eng_start), .eng_func(t_eng_func), .eng_x(t_eng_x),
    .eng_ready(t_eng_ready), .eng_result(t_eng_result),
    .busy(t_busy), .state_dbg(t_state_dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  function automatic logic [EW-1:0] mk(input logic [NREQ-1:0] d, input logic [NREQ-1:0] e,
                                       input logic [W-1:0] r);
    return {d, e, r};
  endfunction

  // Toy engine transfer: byte swap xor function code
  function automatic logic [W-1:0] eng_fn(input logic [1:0] f, input logic [W-1:0] x);
    return {x[7:0], x[15:8]} ^ {14'h0, f};
  endfunction

  // Engine model for the main instance; eng_hold forces Ready low from outside
  logic eng_rdy_m;
  logic eng_hold;
  int   eng_lat = 20;
  assign eng_ready = eng_rdy_m && !eng_hold;

  initial begin
    logic [1:0]   f;
    logic [W-1:0] xv;
    eng_rdy_m  = 1'b1;
    eng_result = '0;
    forever begin
      @(negedge clk);
      if (eng_start) begin
        f  = eng_func;
        xv = eng_x;
        eng_rdy_m = 1'b0;
        repeat (eng_lat) @(negedge clk);
        eng_result = eng_fn(f, xv);
        eng_rdy_m  = 1'b1;
      end
    end
  end

  // Hung engine for the watchdog instance: drops Ready on start, never returns
  initial begin
    t_eng_ready  = 1'b1;
    t_eng_result = 16'hBEEF;
    forever begin
      @(negedge clk);
      if (t_eng_start) t_eng_ready = 1'b0;
    end
  end

  // Monitor: compare every done pulse against the scoreboard head
  always @(negedge clk) begin
    if (eng_start) check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
    if (done != '0) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=%b, required no done", done);
      end else begin
        mon_e = exp_q.pop_front();
        check("done",        32'(done),   32'(mon_e[EW-1 -: NREQ]));
        check("err",         32'(err),    32'(mon_e[W+NREQ-1 -: NREQ]));
        check("result",      32'(result), 32'(mon_e[W-1:0]));
        check("gnt_at_done", 32'(gnt),    32'(mon_e[EW-1 -: NREQ]));
      end
    end
  end

  // Driver helpers
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [1:0] f, input logic [W-1:0] x);
    func_in[2*i +: 2] = f;
    x_in[W*i +: W]    = x;
  endtask

  task automatic wait_dones(input int target, input string name);
    int g = 0;
    while (n_done < target && g < 400) begin
      tick();
      g++;
    end
    check(name, 32'(n_done >= target), 32'd1);
  endtask

  task automatic wait_start(input string name, input int bound);
    int g = 0;
    while (!eng_start && g < bound) begin
      tick();
      g++;
    end
    check(name, 32'(eng_start), 32'd1);
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int g = 0;
    while (state_dbg != s && g < 100) begin
      tick();
      g++;
    end
    check(name, 32'(state_dbg), 32'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Directed test sequence
  initial begin
    int base;
    int cyc;
    logic any;
    rst = 1'b1; req = '0; func_in = '0; x_in = '0; eng_hold = 1'b0;
    t_req = '0; t_func_in = '0; t_x_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_gnt",   32'(gnt), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_start", 32'(eng_start), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // Contention: all four held, expect order 0,1,2,3,0
    set_op(0, 2'd0, 16'h1234);
    set_op(1, 2'd1, 16'h00FF);
    set_op(2, 2'd2, 16'h0400);
    set_op(3, 2'd3, 16'hABCD);
    exp_q.push_back(mk(4'b0001, 4'b0000, 16'h3412));
    exp_q.push_back(mk(4'b0010, 4'b0000, 16'hFF01));
    exp_q.push_back(mk(4'b0100, 4'b0000, 16'h0006));
    exp_q.push_back(mk(4'b1000, 4'b0000, 16'hCDA8));
    exp_q.push_back(mk(4'b0001, 4'b0000, 16'h3412));
    base = n_done;
    req = 4'b1111;
    wait_dones(base + 5, "t2_five_dones");
    req = '0;
    tick(); tick();
    check("t2_idle", 32'(busy), 32'd0);

    // Single request on requester 2, Ln of 0x0400
    set_op(2, 2'd2, 16'h0400);
    exp_q.push_back(mk(4'b0100, 4'b0000, 16'h0006));
    base = n_done;
    req = 4'b0100;
    wait_start("t1_start_seen", 20);
    check("t1_gnt",      32'(gnt), 32'h4);
    check("t1_eng_func", 32'(eng_func), 32'd2);
    check("t1_eng_x",    32'(eng_x), 32'h0400);
    tick();
    check("t1_start_one_cycle", 32'(eng_start), 32'd0);
    wait_dones(base + 1, "t1_done_seen");
    req = '0;
    tick(); tick();

    // Engine not ready in IDLE: no grant until Ready returns
    eng_hold = 1'b1;
    set_op(0, 2'd0, 16'h1234);
    exp_q.push_back(mk(4'b0001, 4'b0000, 16'h3412));
    base = n_done;
    req = 4'b0001;
    any = 1'b0;
    repeat (5) begin
      tick();
      any = any | (gnt != '0) | eng_start | busy;
    end
    check("t4_no_grant", 32'(any), 32'd0);
    eng_hold = 1'b0;
    tick();
    check("t4_grant_next", 32'(gnt), 32'h1);
    wait_dones(base + 1, "t4_done_seen");
    req = '0;
    tick(); tick();

    // Reset during WAIT_DONE
    set_op(0, 2'd2, 16'h1234);
    req = 4'b0001;
    wait_state(3'd3, "t5_reach_wait_done");
    rst = 1'b1;
    #1;
    check("t5_gnt",      32'(gnt), 32'd0);
    check("t5_start",    32'(eng_start), 32'd0);
    check("t5_eng_func", 32'(eng_func), 32'd0);
    check("t5_eng_x",    32'(eng_x), 32'd0);
    check("t5_result",   32'(result), 32'd0);
    check("t5_busy",     32'(busy), 32'd0);
    check("t5_state",    32'(state_dbg), 32'd0);
    req = '0;
    tick();
    rst = 1'b0;
    set_op(1, 2'd1, 16'h00FF);
    exp_q.push_back(mk(4'b0010, 4'b0000, 16'hFF01));
    base = n_done;
    req = 4'b0010;
    wait_start("t5_regrant_start", 60);
    check("t5_gnt_after", 32'(gnt), 32'h2);
    wait_dones(base + 1, "t5_done_seen");
    req = '0;
    tick(); tick();

    // Withdraw request and change operand mid-transaction
    set_op(1, 2'd1, 16'h1122);
    exp_q.push_back(mk(4'b0010, 4'b0000, 16'h2210));
    base = n_done;
    req = 4'b0010;
    wait_state(3'd3, "t6_reach_wait_done");
    req = '0;
    set_op(1, 2'd3, 16'hFFFF);
    tick();
    check("t6_eng_x_held",    32'(eng_x), 32'h1122);
    check("t6_eng_func_held", 32'(eng_func), 32'd1);
    wait_dones(base + 1, "t6_done_seen");
    tick(); tick();

    // Timeout on the TMO=16 instance with a hung engine
    t_req = 4'b0100;
    cyc = 0;
    while (t_state_dbg != 3'd2 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("t3_wait_busy_entry", 32'(t_state_dbg), 32'd2);
    cyc = 0;
    while (t_done == '0 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("t3_latency", 32'(cyc), 32'd16);
    check("t3_done",    32'(t_done), 32'h4);
    check("t3_err",     32'(t_err), 32'h4);
    check("t3_result",  32'(t_result), 32'd0);
    tick();
    check("t3_not_busy", 32'(t_busy), 32'd0);
    t_req = 4'b0101;
    any = 1'b0;
    repeat (10) begin
      tick();
      any = any | (t_gnt != '0) | t_eng_start;
    end
    check("t3_no_regrant", 32'(any), 32'd0);
    t_req = '0;

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/math_func_sched.md
Name: math_func_sched

Overview:
- Round-robin scheduler that shares one iterative math engine (sin/cos/Ln/exp, selected by a 2-bit function code) among NREQ requesters.
- Arbitrates pending requests and latches the winner's operand and function code.
- Drives the engine's start/Ready handshake: start high for one cycle, then low, then waits for Ready to fall and rise again.
- Returns the result with a per-requester done pulse; a watchdog aborts a transaction if the engine never completes.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 16, operand/result width
TMO, 1024, max cycles from start deassertion to engine Ready before timeout (>=4)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req  in  NREQ  level request per requester; held until done
func_in  in  2*NREQ  function code per requester, slice i = [2i+1:2i]; 0=sin 1=cos 2=Ln 3=exp
x_in  in  W*NREQ  operand per requester, slice i = [W*i+W-1:W*i]
gnt  out  NREQ  one-hot grant, high from arbitration through DELIVER/ERR
done  out  NREQ  one-cycle pulse to the granted requester when its transaction ends
err  out  NREQ  one-cycle pulse coincident with done when the transaction timed out
result  out  W  registered result; valid in the done cycle, held until the next done
eng_start  out  1  engine start
eng_func  out  2  latched function code to engine
eng_x  out  W  latched operand to engine
eng_ready  in  1  engine Ready (high when engine idle)
eng_result  in  W  engine result, valid while eng_ready=1 after completion
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: state=IDLE; gnt, done, err, eng_start, eng_func, eng_x, result = 0; rr pointer = NREQ-1, so requester 0 has first priority; timeout counter = 0.
- IDLE:
  - If |req and eng_ready=1: pick the first requester with req set, searching from pointer+1 upward modulo NREQ.
  - Register gnt; latch eng_func and eng_x from that requester's slices; go to LAUNCH.
  - If eng_ready=0, stay in IDLE and grant nothing.
- LAUNCH: eng_start=1 for exactly one cycle; go to WAIT_BUSY; clear timeout counter.
- WAIT_BUSY: eng_start=0; counter increments; eng_ready=0 -> WAIT_DONE.
- WAIT_DONE: counter increments; eng_ready=1 -> DELIVER.
- Timeout: in WAIT_BUSY or WAIT_DONE, when the counter reaches TMO-1 with no exit condition, go to ERR. Ready returning in that same cycle takes priority (DELIVER).
- DELIVER: result<=eng_result; done[g]=1 for one cycle; pointer<=g; go to IDLE, clearing gnt on that transition.
- ERR: result<=0; done[g]=1 and err[g]=1 for one cycle; pointer<=g; go to IDLE.
  - The scheduler never re-starts an engine that reports eng_ready=0, so a hung engine blocks further grants without any extra logic.
- Latency and throughput:
  - Minimum latency from req (IDLE, engine ready) to done is engine cycles + 4.
  - Back-to-back: IDLE arbitration is the cycle after DELIVER, so a new grant is issued the cycle after the done pulse.
- Request rules:
  - req or operands changing after grant have no effect; eng_x and eng_func stay latched.
  - If req drops mid-transaction, the transaction still completes and pulses done.
- Round-robin: the granted requester becomes lowest priority next arbitration. A lone requester is re-granted immediately.
- Counter width: clog2(TMO)+1 bits; it never wraps.
- Reset mid-operation returns everything to reset values immediately. Engine state is the engine's own concern, since it shares rst.
- done and err are registered outputs with no combinational path from req.

Test Plan:
1. Single request: req=4'b0100, func=2 (Ln), x=16'h0400; engine model asserts Ready 20 cycles after start falls → gnt=0100, eng_start pulses 1 cycle with eng_func=2 and eng_x=0400, done=0100 with result equal to the model output, err=0.
2. Contention: req=4'b1111 held continuously → grant order 0,1,2,3,0; each done matches its own operand; exactly one gnt bit set at any time.
3. Timeout: TMO=16, engine drops Ready and never raises it → done and err pulse on the granted bit 16 cycles after the WAIT_BUSY entry, result=0, busy then low; later requests are not granted while eng_ready=0.
4. Engine not ready: eng_ready=0 in IDLE with req=0001 → no gnt, no eng_start until eng_ready=1; grant follows the next cycle.
5. Reset mid-operation: assert rst during WAIT_DONE → all outputs 0 and state IDLE asynchronously; after release, req=0010 is granted first.
6. Request withdrawn and operand changed after grant: req[1] drops and x_in changes during WAIT_DONE → eng_x unchanged; done[1] still pulses with the engine result.
